// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined MIPS control unit.
// Decodes the ID-stage instruction into a control bundle and carries it through
// ID/EX, EX/MEM and MEM/WB registers. Also detects load-use hazards, applies
// external stall / branch flush, and keeps a sticky illegal-encoding flag.
module ctrl_pipe #(
    parameter int INSTR_W    = 32,
    parameter int ALUOP_W    = 6,
    parameter int REG_ADDR_W = 5,
    parameter int HAZARD_EN  = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [INSTR_W-1:0]    Instruction,
    input  logic                  InstrValid,
    input  logic                  Stall,
    input  logic                  Flush,
    output logic                  HazardStall,
    output logic                  IllegalOp,
    output logic                  ExValid,
    output logic                  ExRegDst,
    output logic                  ExALUSrc,
    output logic                  ExBranch,
    output logic                  ExBranchNe,
    output logic                  ExJump,
    output logic [ALUOP_W-1:0]    ExALUOp,
    output logic                  MemValid,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  WbValid,
    output logic                  WbMemtoReg,
    output logic                  WbRegWrite,
    output logic [REG_ADDR_W-1:0] WbWriteReg
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // The EX stage keeps the full bundle plus rt, which the hazard check needs.
    typedef struct packed {
        logic                  valid;
        logic                  reg_dst;
        logic                  alu_src;
        logic                  branch;
        logic                  branch_ne;
        logic                  jump;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [ALUOP_W-1:0]    alu_op;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_ADDR_W-1:0] rt;
    } ex_ctrl_t;

    typedef struct packed {
        logic                  valid;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] dest;
    } mem_ctrl_t;

    typedef struct packed {
        logic                  valid;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] dest;
    } wb_ctrl_t;

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  unused_shamt;

    assign opcode       = Instruction[31:26];
    assign funct        = Instruction[5:0];
    assign rs           = Instruction[21 +: REG_ADDR_W];
    assign rt           = Instruction[16 +: REG_ADDR_W];
    assign rd           = Instruction[11 +: REG_ADDR_W];
    assign unused_shamt = ^Instruction[10:6];

    ex_ctrl_t  dec;
    ex_ctrl_t  id_ctrl;
    logic      legal;
    logic      reads_rt;
    logic      hazard;

    ex_ctrl_t  ex_d, ex_q;
    mem_ctrl_t mem_d, mem_q;
    wb_ctrl_t  wb_d, wb_q;
    logic      illegal_d, illegal_q;

    // Decode the ID instruction; illegal encodings and bubbles collapse to all-zero.
    always_comb begin
        dec      = '0;
        legal    = 1'b0;
        reads_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reads_rt      = 1'b1;
                dec.reg_dst   = 1'b1;
                dec.alu_op    = ALUOP_W'(funct);
                dec.reg_write = 1'b1;
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
                    default:                               legal = 1'b0;
                endcase
            end
            OP_LW: begin
                legal          = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = ALUOP_W'(FN_ADD);
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
            end
            OP_SW: begin
                legal         = 1'b1;
                reads_rt      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALUOP_W'(FN_ADD);
                dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                legal      = 1'b1;
                reads_rt   = 1'b1;
                dec.alu_op = ALUOP_W'(FN_SUB);
                dec.branch = 1'b1;
            end
            OP_BNE: begin
                legal         = 1'b1;
                reads_rt      = 1'b1;
                dec.alu_op    = ALUOP_W'(FN_SUB);
                dec.branch    = 1'b1;
                dec.branch_ne = 1'b1;
            end
            OP_ADDI: begin
                legal         = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALUOP_W'(FN_ADD);
                dec.reg_write = 1'b1;
            end
            OP_J: begin
                legal    = 1'b1;
                dec.jump = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        dec.valid = 1'b1;
        dec.rt    = rt;
        dec.dest  = dec.reg_dst ? rd : rt;
        // Writes to $0 are architecturally discarded, so never request them.
        if (dec.dest == '0) begin
            dec.reg_write = 1'b0;
        end
        id_ctrl = (InstrValid && legal) ? dec : '0;
    end

    // Load-use detection against the load currently sitting in EX.
    always_comb begin
        hazard = InstrValid && ex_q.valid && ex_q.mem_read && (ex_q.rt != '0) &&
                 ((ex_q.rt == rs) || ((ex_q.rt == rt) && reads_rt));
        HazardStall = (HAZARD_EN != 0) && hazard;
    end

    // Stage-register next state: Stall freezes everything, Flush/hazard inject a bubble.
    always_comb begin
        ex_d      = ex_q;
        mem_d     = mem_q;
        wb_d      = wb_q;
        illegal_d = illegal_q;
        if (!Stall) begin
            wb_d.valid       = mem_q.valid;
            wb_d.mem_to_reg  = mem_q.mem_to_reg;
            wb_d.reg_write   = mem_q.reg_write;
            wb_d.dest        = mem_q.dest;
            mem_d.valid      = ex_q.valid;
            mem_d.mem_read   = ex_q.mem_read;
            mem_d.mem_write  = ex_q.mem_write;
            mem_d.mem_to_reg = ex_q.mem_to_reg;
            mem_d.reg_write  = ex_q.reg_write;
            mem_d.dest       = ex_q.dest;
            if (Flush || HazardStall) begin
                ex_d = '0;
            end else begin
                ex_d = id_ctrl;
            end
            if (InstrValid && !legal && !Flush) begin
                illegal_d = 1'b1;
            end
        end
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end

    assign IllegalOp  = illegal_q;
    assign ExValid    = ex_q.valid;
    assign ExRegDst   = ex_q.reg_dst;
    assign ExALUSrc   = ex_q.alu_src;
    assign ExBranch   = ex_q.branch;
    assign ExBranchNe = ex_q.branch_ne;
    assign ExJump     = ex_q.jump;
    assign ExALUOp    = ex_q.alu_op;
    assign MemValid   = mem_q.valid;
    assign MemRead    = mem_q.mem_read;
    assign MemWrite   = mem_q.mem_write;
    assign WbValid    = wb_q.valid;
    assign WbMemtoReg = wb_q.mem_to_reg;
    assign WbRegWrite = wb_q.reg_write;
    assign WbWriteReg = wb_q.dest;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed testbench for ctrl_pipe with hand-computed expectations.
module tb_ctrl_pipe;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        Stall;
    logic        Flush;

    logic       HazardStall, IllegalOp;
    logic       ExValid, ExRegDst, ExALUSrc, ExBranch, ExBranchNe, ExJump;
    logic [5:0] ExALUOp;
    logic       MemValid, MemRead, MemWrite;
    logic       WbValid, WbMemtoReg, WbRegWrite;
    logic [4:0] WbWriteReg;

    logic       nh_HazardStall, nh_IllegalOp;
    logic       nh_ExValid, nh_ExRegDst, nh_ExALUSrc, nh_ExBranch, nh_ExBranchNe, nh_ExJump;
    logic [5:0] nh_ExALUOp;
    logic       nh_MemValid, nh_MemRead, nh_MemWrite;
    logic       nh_WbValid, nh_WbMemtoReg, nh_WbRegWrite;
    logic [4:0] nh_WbWriteReg;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    ctrl_pipe #(.INSTR_W(32), .ALUOP_W(6), .REG_ADDR_W(5), .HAZARD_EN(1)) dut (
        .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InstrValid(InstrValid),
        .Stall(Stall), .Flush(Flush), .HazardStall(HazardStall), .IllegalOp(IllegalOp),
        .ExValid(ExValid), .ExRegDst(ExRegDst), .ExALUSrc(ExALUSrc), .ExBranch(ExBranch),
        .ExBranchNe(ExBranchNe), .ExJump(ExJump), .ExALUOp(ExALUOp),
        .MemValid(MemValid), .MemRead(MemRead), .MemWrite(MemWrite),
        .WbValid(WbValid), .WbMemtoReg(WbMemtoReg), .WbRegWrite(WbRegWrite),
        .WbWriteReg(WbWriteReg)
    );

    ctrl_pipe #(.INSTR_W(32), .ALUOP_W(6), .REG_ADDR_W(5), .HAZARD_EN(0)) dut_nh (
        .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InstrValid(InstrValid),
        .Stall(Stall), .Flush(Flush), .HazardStall(nh_HazardStall), .IllegalOp(nh_IllegalOp),
        .ExValid(nh_ExValid), .ExRegDst(nh_ExRegDst), .ExALUSrc(nh_ExALUSrc),
        .ExBranch(nh_ExBranch), .ExBranchNe(nh_ExBranchNe), .ExJump(nh_ExJump),
        .ExALUOp(nh_ExALUOp), .MemValid(nh_MemValid), .MemRead(nh_MemRead),
        .MemWrite(nh_MemWrite), .WbValid(nh_WbValid), .WbMemtoReg(nh_WbMemtoReg),
        .WbRegWrite(nh_WbRegWrite), .WbWriteReg(nh_WbWriteReg)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic valid);
        Instruction = instr;
        InstrValid  = valid;
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
        present(32'h0, 1'b0);
        tick(); tick();
        checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %0h want 0", ExValid); end
        checks++; if (ExALUOp !== 6'h00) begin errors++; $display("FAIL reset_ex_aluop got %0h want 0", ExALUOp); end
        checks++; if (MemValid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %0h want 0", MemValid); end
        checks++; if (WbRegWrite !== 1'b0) begin errors++; $display("FAIL reset_wb_regwrite got %0h want 0", WbRegWrite); end
        checks++; if (WbWriteReg !== 5'd0) begin errors++; $display("FAIL reset_wb_writereg got %0h want 0", WbWriteReg); end
        checks++; if (IllegalOp !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0h want 0", IllegalOp); end
        checks++; if (HazardStall !== 1'b0) begin errors++; $display("FAIL reset_hazard got %0h want 0", HazardStall); end
        Rst = 1'b1;
    endtask

    task automatic test_rtype();
        present(32'h00221820, 1'b1);
        tick();
        checks++; if (ExValid !== 1'b1) begin errors++; $display("FAIL add_ex_valid got %0h want 1", ExValid); end
        checks++; if (ExRegDst !== 1'b1) begin errors++; $display("FAIL add_ex_regdst got %0h want 1", ExRegDst); end
        checks++; if (ExALUOp !== 6'h20) begin errors++; $display("FAIL add_ex_aluop got %0h want 20", ExALUOp); end
        present(32'h0, 1'b0);
        tick();
        checks++; if (MemValid !== 1'b1 || MemRead !== 1'b0) begin errors++; $display("FAIL add_mem got valid=%0h read=%0h want 1/0", MemValid, MemRead); end
        tick();
        checks++; if (WbRegWrite !== 1'b1) begin errors++; $display("FAIL add_wb_regwrite got %0h want 1", WbRegWrite); end
        checks++; if (WbWriteReg !== 5'd3) begin errors++; $display("FAIL add_wb_writereg got %0d want 3", WbWriteReg); end
        checks++; if (WbMemtoReg !== 1'b0) begin errors++; $display("FAIL add_wb_memtoreg got %0h want 0", WbMemtoReg); end
    endtask

    task automatic test_load_use();
        present(32'h8C220000, 1'b1);
        checks++; if (HazardStall !== 1'b0) begin errors++; $display("FAIL lu_no_hazard_before got %0h want 0", HazardStall); end
        tick();
        present(32'h00432020, 1'b1);
        checks++; if (HazardStall !== 1'b1) begin errors++; $display("FAIL lu_hazard got %0h want 1", HazardStall); end
        checks++; if (nh_HazardStall !== 1'b0) begin errors++; $display("FAIL lu_nohazard_param got %0h want 0", nh_HazardStall); end
        tick();
        checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL lu_ex_bubble got %0h want 0", ExValid); end
        checks++; if (MemRead !== 1'b1) begin errors++; $display("FAIL lu_mem_read got %0h want 1", MemRead); end
        checks++; if (HazardStall !== 1'b0) begin errors++; $display("FAIL lu_hazard_one_cycle got %0h want 0", HazardStall); end
        checks++; if (nh_ExValid !== 1'b1) begin errors++; $display("FAIL lu_nohazard_ex_valid got %0h want 1", nh_ExValid); end
        tick();
        checks++; if (ExValid !== 1'b1 || ExALUOp !== 6'h20) begin errors++; $display("FAIL lu_add_ex got valid=%0h aluop=%0h want 1/20", ExValid, ExALUOp); end
        checks++; if (WbMemtoReg !== 1'b1) begin errors++; $display("FAIL lu_wb_memtoreg got %0h want 1", WbMemtoReg); end
        checks++; if (WbWriteReg !== 5'd2) begin errors++; $display("FAIL lu_wb_writereg got %0d want 2", WbWriteReg); end
        present(32'h0, 1'b0);
        tick(); tick(); tick();
    endtask

    task automatic test_store();
        present(32'hAC220004, 1'b1);
        tick();
        checks++; if (ExALUSrc !== 1'b1 || ExRegDst !== 1'b0) begin errors++; $display("FAIL sw_ex got alusrc=%0h regdst=%0h want 1/0", ExALUSrc, ExRegDst); end
        present(32'h0, 1'b0);
        tick();
        checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL sw_mem_write got %0h want 1", MemWrite); end
        checks++; if (MemRead !== 1'b0) begin errors++; $display("FAIL sw_mem_read got %0h want 0", MemRead); end
        tick();
        checks++; if (WbValid !== 1'b1 || WbRegWrite !== 1'b0) begin errors++; $display("FAIL sw_wb got valid=%0h regwrite=%0h want 1/0", WbValid, WbRegWrite); end
    endtask

    task automatic test_flush_branch();
        present(32'h10220002, 1'b1);
        tick();
        checks++; if (ExBranch !== 1'b1 || ExBranchNe !== 1'b0 || ExALUOp !== 6'h22) begin errors++; $display("FAIL beq_ex got br=%0h bne=%0h aluop=%0h want 1/0/22", ExBranch, ExBranchNe, ExALUOp); end
        present(32'h20210001, 1'b1);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        present(32'h0, 1'b0);
        checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL flush_ex_bubble got %0h want 0", ExValid); end
        tick();
        checks++; if (WbValid !== 1'b1 || WbRegWrite !== 1'b0) begin errors++; $display("FAIL flush_wb_beq got valid=%0h regwrite=%0h want 1/0", WbValid, WbRegWrite); end
        tick();
        checks++; if (WbValid !== 1'b0 || WbRegWrite !== 1'b0) begin errors++; $display("FAIL flush_addi_reached_wb got valid=%0h regwrite=%0h want 0/0", WbValid, WbRegWrite); end
        present(32'h14220003, 1'b1);
        tick();
        checks++; if (ExBranch !== 1'b1 || ExBranchNe !== 1'b1 || ExALUOp !== 6'h22) begin errors++; $display("FAIL bne_ex got br=%0h bne=%0h aluop=%0h want 1/1/22", ExBranch, ExBranchNe, ExALUOp); end
        checks++; if (ExJump !== 1'b0) begin errors++; $display("FAIL bne_ex_jump got %0h want 0", ExJump); end
        present(32'h0, 1'b0);
        tick(); tick(); tick();
    endtask

    task automatic test_stall();
        present(32'h00221820, 1'b1); tick();
        present(32'h20210001, 1'b1); tick();
        present(32'h00432020, 1'b1); tick();
        present(32'hAC220004, 1'b1);
        Stall = 1'b1;
        Flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ExValid !== 1'b1 || ExRegDst !== 1'b1 || ExALUOp !== 6'h20) begin errors++; $display("FAIL stall_ex_%0d got valid=%0h regdst=%0h aluop=%0h want 1/1/20", i, ExValid, ExRegDst, ExALUOp); end
            checks++; if (MemValid !== 1'b1 || WbWriteReg !== 5'd3 || WbRegWrite !== 1'b1) begin errors++; $display("FAIL stall_memwb_%0d got mv=%0h wreg=%0d rw=%0h want 1/3/1", i, MemValid, WbWriteReg, WbRegWrite); end
        end
        Stall = 1'b0;
        Flush = 1'b0;
        tick();
        checks++; if (ExALUSrc !== 1'b1 || ExRegDst !== 1'b0 || ExValid !== 1'b1) begin errors++; $display("FAIL resume_ex_sw got alusrc=%0h regdst=%0h valid=%0h want 1/0/1", ExALUSrc, ExRegDst, ExValid); end
        checks++; if (WbWriteReg !== 5'd1 || WbRegWrite !== 1'b1) begin errors++; $display("FAIL resume_wb_addi got wreg=%0d rw=%0h want 1/1", WbWriteReg, WbRegWrite); end
        present(32'h0, 1'b0);
        tick();
        checks++; if (WbWriteReg !== 5'd4 || WbRegWrite !== 1'b1) begin errors++; $display("FAIL resume_wb_add got wreg=%0d rw=%0h want 4/1", WbWriteReg, WbRegWrite); end
        tick();
        checks++; if (WbValid !== 1'b1 || WbRegWrite !== 1'b0) begin errors++; $display("FAIL resume_wb_sw got valid=%0h rw=%0h want 1/0", WbValid, WbRegWrite); end
        tick();
        checks++; if (WbValid !== 1'b0) begin errors++; $display("FAIL resume_no_dup got %0h want 0", WbValid); end
    endtask

    task automatic test_illegal_opcode();
        checks++; if (IllegalOp !== 1'b0) begin errors++; $display("FAIL illegal_pre got %0h want 0", IllegalOp); end
        present(32'hFC000000, 1'b1);
        tick();
        checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL illegal_op_ex got %0h want 0", ExValid); end
        checks++; if (IllegalOp !== 1'b1) begin errors++; $display("FAIL illegal_op_set got %0h want 1", IllegalOp); end
        present(32'h0, 1'b0);
        tick(); tick();
        checks++; if (IllegalOp !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %0h want 1", IllegalOp); end
    endtask

    task automatic test_reset_mid();
        present(32'h20210001, 1'b1); tick();
        present(32'h8C220000, 1'b1); tick();
        present(32'h00432020, 1'b1);
        checks++; if (HazardStall !== 1'b1) begin errors++; $display("FAIL rstmid_hazard got %0h want 1", HazardStall); end
        Rst = 1'b0;
        tick();
        checks++; if (ExValid !== 1'b0 || ExALUOp !== 6'h00 || ExALUSrc !== 1'b0) begin errors++; $display("FAIL rstmid_ex got valid=%0h aluop=%0h alusrc=%0h want 0/0/0", ExValid, ExALUOp, ExALUSrc); end
        checks++; if (MemValid !== 1'b0 || MemRead !== 1'b0) begin errors++; $display("FAIL rstmid_mem got valid=%0h read=%0h want 0/0", MemValid, MemRead); end
        checks++; if (WbValid !== 1'b0 || WbRegWrite !== 1'b0 || WbWriteReg !== 5'd0) begin errors++; $display("FAIL rstmid_wb got valid=%0h rw=%0h wreg=%0d want 0/0/0", WbValid, WbRegWrite, WbWriteReg); end
        checks++; if (IllegalOp !== 1'b0) begin errors++; $display("FAIL rstmid_illegal got %0h want 0", IllegalOp); end
        checks++; if (HazardStall !== 1'b0) begin errors++; $display("FAIL rstmid_hazard_clear got %0h want 0", HazardStall); end
        present(32'h0, 1'b0);
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_illegal_funct();
        present(32'h0022183F, 1'b1);
        Flush = 1'b1;
        tick();
        checks++; if (IllegalOp !== 1'b0) begin errors++; $display("FAIL illegal_flushed got %0h want 0", IllegalOp); end
        Flush = 1'b0;
        tick();
        checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL illegal_funct_ex got %0h want 0", ExValid); end
        checks++; if (IllegalOp !== 1'b1) begin errors++; $display("FAIL illegal_funct_set got %0h want 1", IllegalOp); end
        present(32'h0, 1'b0);
        tick();
        checks++; if (IllegalOp !== 1'b1 || MemValid !== 1'b0) begin errors++; $display("FAIL illegal_funct_after got ill=%0h mv=%0h want 1/0", IllegalOp, MemValid); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_use();
        test_store();
        test_flush_branch();
        test_stall();
        test_illegal_opcode();
        test_reset_mid();
        test_illegal_funct();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Parametrised pipelined MIPS control unit. It decodes the ID-stage instruction and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers, so each downstream stage reads its own control bits. It also detects load-use hazards, handles external stall and branch flush, and flags illegal encodings. It sits between the IF/ID register and the datapath stage registers.

Parameters:
INSTR_W, 32, instruction width (fields at MIPS positions; must be 32)
ALUOP_W, 6, ALUOp width; funct codes are zero-extended into it; must be >= 6
REG_ADDR_W, 5, register-specifier width
HAZARD_EN, 1, 1 enables load-use detection; 0 ties HazardStall to 0

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, synchronous, active-low
Instruction  in  INSTR_W  ID-stage instruction
InstrValid  in  1  Instruction is real (0 = bubble)
Stall  in  1  external freeze of all stage registers
Flush  in  1  kill the instruction in ID (branch/jump taken)
HazardStall  out  1  combinational; hold PC and IF/ID
IllegalOp  out  1  sticky illegal-encoding flag
ExValid, ExRegDst, ExALUSrc, ExBranch, ExBranchNe, ExJump  out  1 each  EX-stage controls
ExALUOp  out  ALUOP_W  EX-stage ALU operation
MemValid, MemRead, MemWrite  out  1 each  MEM-stage controls
WbValid, WbMemtoReg, WbRegWrite  out  1 each  WB-stage controls
WbWriteReg  out  REG_ADDR_W  destination register in WB

Behaviour:
- Reset (Rst==0 at a rising edge): every registered output is 0, IllegalOp is 0, and all stages hold bubbles. Rst has priority over every other input, including mid-operation.
- Decode table (opcode -> RegDst, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, RegWrite, Branch, BranchNe, Jump); unlisted bits are 0:
  - 000000 R-type: RegDst=1, ALUOp=funct, RegWrite=1. Legal funct values are 100000, 100010, 100100, 100101, 101010.
  - 100011 lw: ALUSrc=1, ALUOp=100000, MemRead=1, MemtoReg=1, RegWrite=1.
  - 101011 sw: ALUSrc=1, ALUOp=100000, MemWrite=1.
  - 000100 beq: ALUOp=100010, Branch=1.
  - 000101 bne: ALUOp=100010, Branch=1, BranchNe=1.
  - 001000 addi: ALUSrc=1, ALUOp=100000, RegWrite=1.
  - 000010 j: Jump=1.
- Destination register = RegDst ? rd : rt.
- Register $0 destination: RegWrite is forced to 0 when the destination is 0.
- Bubble: all control bits 0, Valid=0, destination 0.
- Latency: an instruction accepted in cycle N appears on Ex* in N+1, Mem* in N+2, Wb* in N+3.
- Per-edge priority, Rst > Stall > Flush > HazardStall > advance:
  - Stall=1: all three stage registers hold; Flush and hazard are ignored that cycle. The IF/ID owner re-presents Flush.
  - Flush=1: EX loads a bubble; MEM and WB advance.
  - HazardStall=1: EX loads a bubble; MEM and WB advance; the ID instruction stays presented.
  - Otherwise EX loads the decode, or a bubble if InstrValid=0; MEM loads EX; WB loads MEM.
- Load-use hazard:
  - HazardStall = HAZARD_EN & InstrValid & ExValid & MemRead_of_EX & (ExRt != 0) & ((ExRt == rs) | (ExRt == rt & ID reads rt)).
  - "ID reads rt" means R-type, sw, beq or bne.
  - HazardStall is combinational from current inputs and EX state; it is not gated by Stall.
- Illegal encodings (unknown opcode, or R-type with an unlisted funct):
  - The instruction is decoded as a bubble.
  - IllegalOp sets on the next edge if InstrValid=1, no Stall and no Flush.
  - IllegalOp stays set until reset.
- Width rules: ALUOp is zero-extended to ALUOP_W; register fields are taken as the low REG_ADDR_W bits of the 5-bit MIPS fields.

Test Plan:
1. Reset, then add $3,$1,$2 (0x00221820) with InstrValid=1 → N+1: ExRegDst=1, ExALUOp=0x20, ExValid=1. N+3: WbRegWrite=1, WbWriteReg=3, WbMemtoReg=0.
2. lw $2,0($1) (0x8C220000), then add $4,$2,$3 (0x00432020) → HazardStall=1 for exactly one cycle and EX holds a bubble (ExValid=0). The add then reaches EX with ExALUOp=0x20. The lw reaches WB with WbMemtoReg=1, WbWriteReg=2.
3. sw $2,4($1) (0xAC220004) → N+2: MemWrite=1, MemRead=0. N+3: WbRegWrite=0. With HAZARD_EN=0 in case 2, HazardStall stays 0.
4. beq in EX and Flush=1 with a valid addi (0x20210001) in ID → the next EX is a bubble and the addi never reaches WB. bne (0x14220003) → ExBranch=1, ExBranchNe=1, ExALUOp=0x22.
5. Stall=1 for 3 cycles with 3 instructions in flight → all outputs frozen. Flush asserted concurrently has no effect. The pipeline resumes with no loss or duplication.
6. Instruction 0xFC000000 or funct 0x3F with InstrValid=1 → EX bubble, IllegalOp=1 and it stays 1. Rst=0 mid-flight (including during HazardStall) → next edge: all outputs 0, IllegalOp=0.
